// File: rtl/load_store_unit.sv
// Load/store unit for the 8-bit core: one memory access per command.
// Captures the pointer pair, store byte and register selects on start.
// Runs a req/ack bus transaction, then pulses the write-back strobes.
// Ports: clk/reset (sync, active-high); start/op_store/ptr_sel/rd_sel/
//   ptr_pair/st_data/post_inc command inputs; mem_* data-memory bus;
//   rf_* register-file write-back and post-increment; busy/done/err.
// Option: define LSU_TIMEOUT_EN to abort REQ after TIMEOUT cycles with err.
module load_store_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_store,
    input  logic [3:0]        ptr_sel,
    input  logic [3:0]        rd_sel,
    input  logic [ADDR_W-1:0] ptr_pair,
    input  logic [DATA_W-1:0] st_data,
    input  logic [8:0]        post_inc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_write_en,
    output logic [3:0]        rf_a_select,
    output logic              rf_add,
    output logic [3:0]        rf_b_select,
    output logic [8:0]        rf_constant,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT must fit the 8-bit counter");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        rd_q, rd_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [8:0]        inc_q, inc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic req_q, req_d;
    logic we_q, we_d;
    logic wen_q, wen_d;
    logic add_q, add_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic timed_out;
    logic hazard;
    logic wb_go;

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        ptr_d     = ptr_q;
        inc_d     = inc_q;
        rdata_d   = rdata_q;
        timed_out = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_store;
                    addr_d  = ptr_pair;
                    wdata_d = st_data;
                    rd_d    = rd_sel;
                    ptr_d   = ptr_sel;
                    inc_d   = post_inc;
                    state_d = REQ;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = WB;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = WB;
                    timed_out = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A load into either half of the pointer pair beats the increment.
        hazard = !op_q && (rd_q[3:1] == ptr_q[3:1]);
        wb_go  = (state_q == REQ) && (state_d == WB) && !timed_out;

        req_d  = (state_d == REQ);
        we_d   = (state_d == REQ) && op_d;
        busy_d = (state_d != IDLE);
        done_d = (state_d == WB);
        wen_d  = wb_go && !op_q;
        add_d  = wb_go && (inc_q != 9'd0) && !hazard;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 4'd0;
            ptr_q   <= 4'd0;
            inc_q   <= 9'd0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wen_q   <= 1'b0;
            add_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            ptr_q   <= ptr_d;
            inc_q   <= inc_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wen_q   <= wen_d;
            add_q   <= add_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign rf_din      = rdata_q;
    assign rf_write_en = wen_q;
    assign rf_a_select = rd_q;
    assign rf_add      = add_q;
    assign rf_b_select = ptr_q & 4'b1110;
    assign rf_constant = inc_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef LSU_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
